// File: rtl/alu_seq.sv
// Sequential ALU: start/busy/done handshake, internal carry and multiply high word.
// Operands are latched on acceptance; single-cycle ops complete on the following edge.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] rd,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             jump,
  output logic             done,
  output logic             busy,
  output logic             halted
);

  localparam logic [5:0] OP_JMP  = 6'b000000, OP_JLT  = 6'b000100, OP_JGT = 6'b000101;
  localparam logic [5:0] OP_JEQ  = 6'b000110, OP_JZ   = 6'b000111, OP_JGE = 6'b001000;
  localparam logic [5:0] OP_JLE  = 6'b001001, OP_JNE  = 6'b001010, OP_JN  = 6'b001011;
  localparam logic [5:0] OP_AND  = 6'b001100, OP_OR   = 6'b001101, OP_XOR = 6'b001110;
  localparam logic [5:0] OP_NOT  = 6'b001111, OP_NAND = 6'b010000, OP_NOR = 6'b010001;
  localparam logic [5:0] OP_XNOR = 6'b010010, OP_MOV  = 6'b010011, OP_ADD = 6'b010100;
  localparam logic [5:0] OP_ADC  = 6'b010101, OP_ADO  = 6'b010110, OP_SUB = 6'b011000;
  localparam logic [5:0] OP_SBC  = 6'b011001, OP_SBO  = 6'b011010, OP_MUL = 6'b011100;
  localparam logic [5:0] OP_MLA  = 6'b011101, OP_MRT  = 6'b011111, OP_LSL = 6'b100000;
  localparam logic [5:0] OP_LSR  = 6'b100001, OP_ASR  = 6'b100010, OP_ROR = 6'b100100;
  localparam logic [5:0] OP_RRC  = 6'b100101, OP_STP  = 6'b111111;

  localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] RRC_MOD  = WIDTH'(WIDTH + 1);
  localparam logic [WIDTH:0]   ONE_X    = (WIDTH + 1)'(1);
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_e;

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic [5:0]         op_q, op_d;
  logic [WIDTH-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [WIDTH-1:0]   result_q, result_d, mulhi_q, mulhi_d, mplier_q, mplier_d;
  logic               carry_q, carry_d, jump_q, jump_d, done_q, done_d;
  logic               busy_q, busy_d, halted_q, halted_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  // Datapath evaluated on the latched operands
  logic [WIDTH:0]          a_x, b_x, c_x, sum;
  logic                    s_lt, s_eq, sh_big;
  logic signed [WIDTH-1:0] asr_raw;
  logic [2*WIDTH-1:0]      ror_wide;
  logic [WIDTH-1:0]        rrc_amt;
  logic [2*WIDTH+1:0]      rrc_wide;

  assign a_x      = {1'b0, rs1_q};
  assign b_x      = {1'b0, rs2_q};
  assign c_x      = {{WIDTH{1'b0}}, carry_q};
  assign s_lt     = $signed(rs1_q) < $signed(rs2_q);
  assign s_eq     = rs1_q == rs2_q;
  assign sh_big   = rs2_q >= W_VAL;
  assign asr_raw  = $signed(rs1_q) >>> rs2_q;
  assign ror_wide = {rs1_q, rs1_q} >> rs2_q[SHW-1:0];
  assign rrc_amt  = rs2_q % RRC_MOD;
  // {rs1,C} is a (WIDTH+1)-bit ring; doubling it turns the rotate into a plain shift
  assign rrc_wide = {rs1_q, carry_q, rs1_q, carry_q} >> rrc_amt;

  logic [WIDTH-1:0] x_res;
  logic             x_wr, x_carry, x_wc, x_jump, is_jmp, is_arith;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    x_res    = '0;
    x_wr     = 1'b0;
    x_carry  = 1'b0;
    x_wc     = 1'b0;
    x_jump   = 1'b0;
    is_jmp   = 1'b0;
    is_arith = 1'b0;
    sum      = '0;
    case (op_q)
      OP_JMP:  begin is_jmp = 1'b1; x_jump = 1'b1;            end
      OP_JLT:  begin is_jmp = 1'b1; x_jump = s_lt;            end
      OP_JGT:  begin is_jmp = 1'b1; x_jump = !s_lt && !s_eq;  end
      OP_JEQ:  begin is_jmp = 1'b1; x_jump = s_eq;            end
      OP_JZ:   begin is_jmp = 1'b1; x_jump = rs1_q == '0;     end
      OP_JGE:  begin is_jmp = 1'b1; x_jump = !s_lt;           end
      OP_JLE:  begin is_jmp = 1'b1; x_jump = s_lt || s_eq;    end
      OP_JNE:  begin is_jmp = 1'b1; x_jump = !s_eq;           end
      OP_JN:   begin is_jmp = 1'b1; x_jump = rs1_q[WIDTH-1];  end
      OP_AND:  begin x_wr = 1'b1; x_res = rs1_q & rs2_q;      end
      OP_OR:   begin x_wr = 1'b1; x_res = rs1_q | rs2_q;      end
      OP_XOR:  begin x_wr = 1'b1; x_res = rs1_q ^ rs2_q;      end
      OP_NOT:  begin x_wr = 1'b1; x_res = ~rs1_q;             end
      OP_NAND: begin x_wr = 1'b1; x_res = ~(rs1_q & rs2_q);   end
      OP_NOR:  begin x_wr = 1'b1; x_res = ~(rs1_q | rs2_q);   end
      OP_XNOR: begin x_wr = 1'b1; x_res = ~(rs1_q ^ rs2_q);   end
      OP_MOV:  begin x_wr = 1'b1; x_res = rs1_q;              end
      OP_ADD:  begin is_arith = 1'b1; sum = a_x + b_x;               end
      OP_ADC:  begin is_arith = 1'b1; sum = a_x + b_x + c_x;         end
      OP_ADO:  begin is_arith = 1'b1; sum = a_x + ONE_X;             end
      OP_SUB:  begin is_arith = 1'b1; sum = a_x - b_x;               end
      OP_SBC:  begin is_arith = 1'b1; sum = a_x - b_x + c_x - ONE_X; end
      OP_SBO:  begin is_arith = 1'b1; sum = a_x - ONE_X;             end
      OP_MRT:  begin x_wr = 1'b1; x_res = mulhi_q;                    end
      OP_LSL:  begin x_wr = 1'b1; x_res = sh_big ? '0 : rs1_q << rs2_q; end
      OP_LSR:  begin x_wr = 1'b1; x_res = sh_big ? '0 : rs1_q >> rs2_q; end
      OP_ASR:  begin
        x_wr  = 1'b1;
        x_res = sh_big ? {WIDTH{rs1_q[WIDTH-1]}} : asr_raw;
      end
      OP_ROR:  begin x_wr = 1'b1; x_res = ror_wide[WIDTH-1:0]; end
      OP_RRC:  begin
        x_wr    = 1'b1;
        x_res   = rrc_wide[WIDTH:1];
        x_wc    = 1'b1;
        x_carry = rrc_wide[0];
      end
      OP_STP:  begin x_wr = 1'b1; x_res = '0; end
      default: ;
    endcase
    if (is_jmp) begin
      x_wr  = 1'b1;
      x_res = rd_q;
    end
    if (is_arith) begin
      x_wr    = 1'b1;
      x_res   = sum[WIDTH-1:0];
      x_wc    = 1'b1;
      x_carry = sum[WIDTH];
    end
  end

  // Multiply step: add shifted multiplicand per set bit; the MSB weight is negative
  logic               is_mul_op, step_last, accept;
  logic [2*WIDTH-1:0] src_acc, src_mcand, step_acc;
  logic [WIDTH-1:0]   src_mplier;

  assign is_mul_op  = (op_q == OP_MUL) || (op_q == OP_MLA);
  assign src_acc    = (state_q == S_MUL) ? acc_q :
                      ((op_q == OP_MLA) ? {{WIDTH{rd_q[WIDTH-1]}}, rd_q} : '0);
  assign src_mcand  = (state_q == S_MUL) ? mcand_q : {{WIDTH{rs1_q[WIDTH-1]}}, rs1_q};
  assign src_mplier = (state_q == S_MUL) ? mplier_q : rs2_q;
  assign step_last  = (state_q == S_MUL) && (cnt_q == CNT_LAST);
  assign step_acc   = !src_mplier[0] ? src_acc :
                      (step_last ? src_acc - src_mcand : src_acc + src_mcand);
  assign accept     = start && !halted_q && !pend_q && (state_q == S_IDLE);

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    result_d = result_q;
    carry_d  = carry_q;
    jump_d   = 1'b0;
    done_d   = 1'b0;
    busy_d   = 1'b0;
    halted_d = halted_q;
    mulhi_d  = mulhi_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (accept) begin
      pend_d = 1'b1;
      op_d   = opcode;
      rd_d   = rd;
      rs1_d  = rs1;
      rs2_d  = rs2;
    end
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (is_mul_op) begin
            acc_d    = step_acc;
            mcand_d  = {src_mcand[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, src_mplier[WIDTH-1:1]};
            cnt_d    = SHW'(1);
            busy_d   = 1'b1;
            state_d  = S_MUL;
          end else begin
            done_d = 1'b1;
            jump_d = x_jump;
            if (x_wr) result_d = x_res;
            if (x_wc) carry_d = x_carry;
            if (op_q == OP_STP) halted_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = step_acc;
        mcand_d  = {src_mcand[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, src_mplier[WIDTH-1:1]};
        cnt_d    = cnt_q + SHW'(1);
        busy_d   = 1'b1;
        if (step_last) state_d = S_FIN;
      end
      S_FIN: begin
        result_d = acc_q[WIDTH-1:0];
        mulhi_d  = acc_q[2*WIDTH-1:WIDTH];
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      jump_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      mulhi_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      jump_q   <= jump_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      mulhi_q  <= mulhi_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign jump   = jump_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16): handshake timing, opcodes, multiply,
// reset abort and halt behaviour, with hand-computed expected values.
module tb_alu_seq;
  localparam int W = 16;

  localparam logic [5:0] OP_JLT = 6'b000100, OP_JGT = 6'b000101, OP_JNE = 6'b001010;
  localparam logic [5:0] OP_JN  = 6'b001011, OP_AND = 6'b001100, OP_XOR = 6'b001110;
  localparam logic [5:0] OP_NOT = 6'b001111, OP_NOR = 6'b010001, OP_XNOR = 6'b010010;
  localparam logic [5:0] OP_MOV = 6'b010011, OP_ADD = 6'b010100, OP_ADC = 6'b010101;
  localparam logic [5:0] OP_ADO = 6'b010110, OP_SUB = 6'b011000, OP_SBC = 6'b011001;
  localparam logic [5:0] OP_SBO = 6'b011010, OP_MUL = 6'b011100, OP_MLA = 6'b011101;
  localparam logic [5:0] OP_MRT = 6'b011111, OP_LSL = 6'b100000, OP_LSR = 6'b100001;
  localparam logic [5:0] OP_ASR = 6'b100010, OP_ROR = 6'b100100, OP_RRC = 6'b100101;
  localparam logic [5:0] OP_STP = 6'b111111, OP_JUNK = 6'b101010;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [5:0]   opcode;
  logic [W-1:0] rd, rs1, rs2, result;
  logic         carry, jump, done, busy, halted;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .result(result), .carry(carry),
    .jump(jump), .done(done), .busy(busy), .halted(halted)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Issue one op, scramble operands afterwards, then wait (bounded) for done.
  task automatic exec(input logic [5:0] op, input logic [W-1:0] v_rd, v_rs1, v_rs2,
                      output int cyc, output int nbusy);
    @(negedge clk);
    opcode = op; rd = v_rd; rs1 = v_rs1; rs2 = v_rs2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; opcode = OP_JUNK;
    rd = 16'($urandom); rs1 = 16'($urandom); rs2 = 16'($urandom);
    cyc = 0; nbusy = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) nbusy++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({result, carry, jump, done, busy, halted} !== 21'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {result, carry, jump, done, busy, halted});
    end
    reset = 1'b0;
  endtask

  task automatic test_arith();
    int cyc, nb;
    exec(OP_ADD, 16'h0, 16'hFFFF, 16'h0001, cyc, nb);
    checks++; if (cyc !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", cyc); end
    checks++; if ({result, carry} !== {16'h0000, 1'b1}) begin failures++; $display("FAIL add got=%h exp=%h", {result, carry}, {16'h0000, 1'b1}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_busy got=%b exp=0", busy); end
    exec(OP_ADC, 16'h0, 16'h0000, 16'h0000, cyc, nb);
    checks++; if ({result, carry} !== {16'h0001, 1'b0}) begin failures++; $display("FAIL adc got=%h exp=%h", {result, carry}, {16'h0001, 1'b0}); end
    exec(OP_SUB, 16'h0, 16'h0003, 16'h0005, cyc, nb);
    checks++; if ({result, carry} !== {16'hFFFE, 1'b1}) begin failures++; $display("FAIL sub got=%h exp=%h", {result, carry}, {16'hFFFE, 1'b1}); end
    exec(OP_SBC, 16'h0, 16'h0010, 16'h0003, cyc, nb);
    checks++; if ({result, carry} !== {16'h000D, 1'b0}) begin failures++; $display("FAIL sbc got=%h exp=%h", {result, carry}, {16'h000D, 1'b0}); end
    exec(OP_ADO, 16'h0, 16'hFFFF, 16'h1234, cyc, nb);
    checks++; if ({result, carry} !== {16'h0000, 1'b1}) begin failures++; $display("FAIL ado got=%h exp=%h", {result, carry}, {16'h0000, 1'b1}); end
    exec(OP_SBO, 16'h0, 16'h0000, 16'h1234, cyc, nb);
    checks++; if ({result, carry} !== {16'hFFFF, 1'b1}) begin failures++; $display("FAIL sbo got=%h exp=%h", {result, carry}, {16'hFFFF, 1'b1}); end
  endtask

  task automatic test_logic();
    int cyc, nb;
    exec(OP_AND, 16'h0, 16'hF0F0, 16'hFF00, cyc, nb);
    checks++; if ({result, carry} !== {16'hF000, 1'b1}) begin failures++; $display("FAIL and_keeps_carry got=%h exp=%h", {result, carry}, {16'hF000, 1'b1}); end
    exec(OP_XOR, 16'h0, 16'hF0F0, 16'hFF00, cyc, nb);
    checks++; if (result !== 16'h0FF0) begin failures++; $display("FAIL xor got=%h exp=0ff0", result); end
    exec(OP_NOR, 16'h0, 16'hF0F0, 16'h0F00, cyc, nb);
    checks++; if (result !== 16'h000F) begin failures++; $display("FAIL nor got=%h exp=000f", result); end
    exec(OP_NOT, 16'h0, 16'h1234, 16'h0000, cyc, nb);
    checks++; if (result !== 16'hEDCB) begin failures++; $display("FAIL not got=%h exp=edcb", result); end
    exec(OP_XNOR, 16'h0, 16'h00FF, 16'h0F0F, cyc, nb);
    checks++; if (result !== 16'hF00F) begin failures++; $display("FAIL xnor got=%h exp=f00f", result); end
  endtask

  task automatic test_jump();
    int cyc, nb;
    exec(OP_JLT, 16'hABCD, 16'hFFFE, 16'h0001, cyc, nb);
    checks++; if ({result, jump} !== {16'hABCD, 1'b1}) begin failures++; $display("FAIL jlt got=%h exp=%h", {result, jump}, {16'hABCD, 1'b1}); end
    @(negedge clk);
    checks++; if (jump !== 1'b0) begin failures++; $display("FAIL jump_after_done got=%b exp=0", jump); end
    exec(OP_JN, 16'h1111, 16'h0001, 16'h0000, cyc, nb);
    checks++; if ({result, jump} !== {16'h1111, 1'b0}) begin failures++; $display("FAIL jn got=%h exp=%h", {result, jump}, {16'h1111, 1'b0}); end
    exec(OP_JGT, 16'h2222, 16'h0001, 16'h8000, cyc, nb);
    checks++; if ({result, jump} !== {16'h2222, 1'b1}) begin failures++; $display("FAIL jgt got=%h exp=%h", {result, jump}, {16'h2222, 1'b1}); end
    exec(OP_JNE, 16'h3333, 16'h0005, 16'h0005, cyc, nb);
    checks++; if ({result, jump} !== {16'h3333, 1'b0}) begin failures++; $display("FAIL jne got=%h exp=%h", {result, jump}, {16'h3333, 1'b0}); end
  endtask

  task automatic test_shift();
    int cyc, nb;
    exec(OP_ADD, 16'h0, 16'h0000, 16'h0000, cyc, nb);
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL clear_carry got=%b exp=0", carry); end
    exec(OP_ASR, 16'h0, 16'h8000, 16'd20, cyc, nb);
    checks++; if (result !== 16'hFFFF) begin failures++; $display("FAIL asr_big got=%h exp=ffff", result); end
    exec(OP_LSL, 16'h0, 16'h0001, 16'd16, cyc, nb);
    checks++; if (result !== 16'h0000) begin failures++; $display("FAIL lsl_big got=%h exp=0000", result); end
    exec(OP_LSR, 16'h0, 16'h8000, 16'd15, cyc, nb);
    checks++; if (result !== 16'h0001) begin failures++; $display("FAIL lsr got=%h exp=0001", result); end
    exec(OP_ROR, 16'h0, 16'h0001, 16'd1, cyc, nb);
    checks++; if (result !== 16'h8000) begin failures++; $display("FAIL ror1 got=%h exp=8000", result); end
    exec(OP_ROR, 16'h0, 16'h1234, 16'd20, cyc, nb);
    checks++; if (result !== 16'h4123) begin failures++; $display("FAIL ror20 got=%h exp=4123", result); end
    exec(OP_RRC, 16'h0, 16'h0001, 16'd1, cyc, nb);
    checks++; if ({result, carry} !== {16'h0000, 1'b1}) begin failures++; $display("FAIL rrc1 got=%h exp=%h", {result, carry}, {16'h0000, 1'b1}); end
    exec(OP_RRC, 16'h0, 16'h0000, 16'd16, cyc, nb);
    checks++; if ({result, carry} !== {16'h0001, 1'b0}) begin failures++; $display("FAIL rrc16 got=%h exp=%h", {result, carry}, {16'h0001, 1'b0}); end
  endtask

  task automatic test_mul();
    int cyc, nb;
    exec(OP_MUL, 16'h0, 16'h7FFF, 16'h7FFF, cyc, nb);
    checks++; if (result !== 16'h0001) begin failures++; $display("FAIL mul_max got=%h exp=0001", result); end
    exec(OP_MRT, 16'h0, 16'h0, 16'h0, cyc, nb);
    checks++; if (result !== 16'h3FFF) begin failures++; $display("FAIL mrt_max got=%h exp=3fff", result); end
    exec(OP_MUL, 16'h0, 16'hFFFD, 16'h0005, cyc, nb);
    checks++; if (cyc !== 17) begin failures++; $display("FAIL mul_latency got=%0d exp=17", cyc); end
    checks++; if (nb !== 16) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=16", nb); end
    checks++; if ({result, busy} !== {16'hFFF1, 1'b0}) begin failures++; $display("FAIL mul_neg got=%h exp=%h", {result, busy}, {16'hFFF1, 1'b0}); end
    exec(OP_MRT, 16'h0, 16'h0, 16'h0, cyc, nb);
    checks++; if (result !== 16'hFFFF) begin failures++; $display("FAIL mrt_neg got=%h exp=ffff", result); end
    exec(OP_MLA, 16'hFFFF, 16'h8000, 16'h8000, cyc, nb);
    checks++; if (result !== 16'hFFFF) begin failures++; $display("FAIL mla got=%h exp=ffff", result); end
    exec(OP_MRT, 16'h0, 16'h0, 16'h0, cyc, nb);
    checks++; if (result !== 16'h3FFF) begin failures++; $display("FAIL mrt_mla got=%h exp=3fff", result); end
  endtask

  task automatic test_busy_ignore();
    int n_done;
    @(negedge clk);
    opcode = OP_MUL; rs1 = 16'h0003; rs2 = 16'h0004; rd = 16'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (i == 3) begin opcode = OP_ADD; rs1 = 16'hFFFF; rs2 = 16'h0001; start = 1'b1; end
      if (i == 6) start = 1'b0;
    end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL busy_ignore_dones got=%0d exp=1", n_done); end
    checks++; if (result !== 16'h000C) begin failures++; $display("FAIL busy_ignore_result got=%h exp=000c", result); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    opcode = OP_MUL; rs1 = 16'hFFFF; rs2 = 16'h0002; rd = 16'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if ({result, done} !== {16'hFFFE, 1'b1}) begin failures++; $display("FAIL b2b_mul got=%h exp=%h", {result, done}, {16'hFFFE, 1'b1}); end
    opcode = OP_MRT; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if ({result, done} !== {16'hFFFF, 1'b1}) begin failures++; $display("FAIL b2b_mrt got=%h exp=%h", {result, done}, {16'hFFFF, 1'b1}); end
  endtask

  task automatic test_reset_mid_mul();
    int cyc, nb, n_done;
    @(negedge clk);
    opcode = OP_MUL; rs1 = 16'h7FFF; rs2 = 16'h7FFF; rd = 16'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_mul_busy got=%b exp=1", busy); end
    reset = 1'b1; opcode = OP_ADD; rs1 = 16'hFFFF; rs2 = 16'h0001; start = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, result, carry} !== 19'h0) begin
      failures++;
      $display("FAIL reset_abort got=%h exp=0", {busy, done, result, carry});
    end
    reset = 1'b0; start = 1'b0;
    n_done = 0;
    repeat (25) begin @(negedge clk); if (done === 1'b1) n_done++; end
    checks++; if (n_done !== 0) begin failures++; $display("FAIL reset_no_writeback got=%0d exp=0", n_done); end
    exec(OP_MOV, 16'h0, 16'h5A5A, 16'h0, cyc, nb);
    exec(OP_MRT, 16'h0, 16'h0, 16'h0, cyc, nb);
    checks++; if (result !== 16'h0000) begin failures++; $display("FAIL reset_mulhi got=%h exp=0000", result); end
  endtask

  task automatic test_halt();
    int cyc, nb, n_done;
    exec(OP_MOV, 16'h0, 16'h1234, 16'h0, cyc, nb);
    exec(OP_STP, 16'h0, 16'hFFFF, 16'hFFFF, cyc, nb);
    checks++; if ({result, halted, done} !== {16'h0000, 1'b1, 1'b1}) begin failures++; $display("FAIL stp got=%h exp=%h", {result, halted, done}, {16'h0000, 1'b1, 1'b1}); end
    @(negedge clk);
    opcode = OP_ADD; rs1 = 16'h0001; rs2 = 16'h0001; start = 1'b1;
    n_done = 0;
    repeat (10) begin @(negedge clk); if (done === 1'b1) n_done++; end
    start = 1'b0;
    checks++; if (n_done !== 0) begin failures++; $display("FAIL halted_no_done got=%0d exp=0", n_done); end
    checks++; if ({halted, result} !== {1'b1, 16'h0000}) begin failures++; $display("FAIL halted_sticky got=%h exp=%h", {halted, result}, {1'b1, 16'h0000}); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_jump();
    test_shift();
    test_mul();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_mul();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
